// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared line-state, SYNC pattern and sequencer state definitions
package usb_rx_pkg;
  typedef enum logic [1:0] {LS_SE0 = 2'b00, LS_K = 2'b01, LS_J = 2'b10, LS_SE1 = 2'b11} line_state_t;
  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_RECV} rx_state_t;
  localparam logic [7:0] SYNC_PATTERN = 8'b01010100;
  function automatic line_state_t line_state(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction
endpackage

// File: rtl/usb_sync_detect.sv
// usb_sync_detect: SYNC hunt shift register with reload on SE0/SE1
module usb_sync_detect
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  logic dp,
  input  logic dm,
  output logic match
);
  logic [7:0] sr, sr_next;
  logic jk;
  // Next shift value; an SE0/SE1 sample restarts the hunt and can never complete SYNC
  always_comb begin
    jk = (line_state(dp, dm) == LS_J) || (line_state(dp, dm) == LS_K);
    sr_next = jk ? {sr[6:0], dp} : 8'hFF;
    match = en && jk && (sr_next == SYNC_PATTERN);
  end
  // Shift register is preloaded with all-J when the hunt begins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= 8'hFF;
    else if (load) sr <= 8'hFF;
    else if (en) sr <= sr_next;
endmodule

// File: rtl/usb_rx_seq.sv
// usb_rx_seq: USB receive sequencer framing packets for the NRZI decoder
module usb_rx_seq
  import usb_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 18,
  parameter int MAX_BITS = 1100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dp,
  input  logic dm,
  input  logic rx_enable,
  input  logic rx_abort,
  output logic s_nrzi,
  output logic start_rc_nrzi,
  output logic end_rc_nrzi,
  output logic rx_busy,
  output logic pkt_ok,
  output logic eop_err,
  output logic line_err,
  output logic len_err,
  output logic timeout,
  output logic [$clog2(MAX_BITS+1)-1:0] bit_cnt
);
  localparam int BW = $clog2(MAX_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BW-1:0] MAX_V = BW'(MAX_BITS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  rx_state_t state;
  line_state_t ls;
  logic [TW-1:0] tcnt;
  logic [1:0] se0_cnt;
  logic jk, recv, enter, match, good, eop_bad, ln_bad, len_bad, pkt_done;
  usb_sync_detect u_sync (
    .clk(clk), .rst_n(rst_n), .en(state == ST_HUNT), .load(enter),
    .dp(dp), .dm(dm), .match(match)
  );
  // Packet-termination decode for the current RECV sample; abort suppresses all flags
  always_comb begin
    ls = line_state(dp, dm);
    jk = (ls == LS_J) || (ls == LS_K);
    enter = (state == ST_IDLE) && rx_enable && !rx_abort;
    recv = (state == ST_RECV) && !rx_abort;
    good = recv && (se0_cnt == 2'd2) && (ls == LS_J);
    eop_bad = recv && (((se0_cnt == 2'd2) && (ls == LS_K || ls == LS_SE0)) || ((se0_cnt == 2'd1) && jk));
    ln_bad = recv && (ls == LS_SE1);
    len_bad = recv && jk && (se0_cnt == 2'd0) && (bit_cnt == MAX_V);
    pkt_done = ((state == ST_RECV) && rx_abort) || good || eop_bad || ln_bad || len_bad;
  end
  // Sequencer FSM with registered pulses and counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      tcnt <= '0;
      se0_cnt <= '0;
      bit_cnt <= '0;
      s_nrzi <= 1'b0;
      start_rc_nrzi <= 1'b0;
      end_rc_nrzi <= 1'b0;
      rx_busy <= 1'b0;
      pkt_ok <= 1'b0;
      eop_err <= 1'b0;
      line_err <= 1'b0;
      len_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      s_nrzi <= dp;
      start_rc_nrzi <= 1'b0;
      timeout <= 1'b0;
      end_rc_nrzi <= pkt_done;
      pkt_ok <= good;
      eop_err <= eop_bad;
      line_err <= ln_bad;
      len_err <= len_bad;
      case (state)
        ST_IDLE: if (enter) begin
          state <= ST_HUNT;
          rx_busy <= 1'b1;
          tcnt <= '0;
        end
        ST_HUNT: if (rx_abort) begin
          state <= ST_IDLE;
          rx_busy <= 1'b0;
        end else if (match) begin
          state <= ST_RECV;
          start_rc_nrzi <= 1'b1;
          bit_cnt <= '0;
          se0_cnt <= '0;
        end else if (tcnt == TO_LAST) begin
          state <= ST_IDLE;
          rx_busy <= 1'b0;
          timeout <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
        ST_RECV: if (pkt_done) begin
          state <= ST_IDLE;
          rx_busy <= 1'b0;
        end else if (ls == LS_SE0) se0_cnt <= se0_cnt + 1'b1;
        else begin
          se0_cnt <= '0;
          bit_cnt <= bit_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule
